// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32 controller; CTRL_ILLEGAL_TRAP_EN adds the ILLEGAL state.
// Latency: none (declarations only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

`ifdef CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;
`else
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
    } state_t;
`endif

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Coarse ALU intent handed from the FSM to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT   = 2'b00;
    localparam logic [1:0] RES_READDATA = 2'b01;
    localparam logic [1:0] RES_ALURES   = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus funct3/funct7b5/op[5] onto the 3-bit ALUControl code.
// Latency: combinational.
// Backpressure: none.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       funct_illegal
`endif
);

    logic unsupported;

    always_comb begin
        alu_control = ALU_ADD;
        unsupported = 1'b0;
        case (alu_op)
            ALUOP_SUB:  alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // Only R-type distinguishes sub; addi ignores instr[30].
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    default: begin
                        alu_control = ALU_ADD;
                        unsupported = 1'b1;
                    end
                endcase
            end
            default:    alu_control = ALU_ADD;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign funct_illegal = unsupported;
`endif

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle RV32 datapath; CTRL_ILLEGAL_TRAP_EN traps unknown ops/funct3.
// Latency: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles, plus one per mem_ready=0 cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold while mem_ready=0, counted in stall_cycles.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             op,
    input  logic [2:0]             funct3,
    input  logic                   funct7b5,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   AdrSrc,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic [1:0]             ResultSrc,
    output logic [1:0]             ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             ImmSrc,
    output logic [2:0]             ALUControl,
    output logic                   RegWrite,
    output logic [STALL_CNT_W-1:0] stall_cycles
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                   illegal_instr
`endif
);

    state_t     state;
    state_t     state_nx;
    logic [1:0] alu_op;
    logic [2:0] alu_control_dec;
    logic       waiting;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic funct_illegal;

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .op5           (op[5]),
        .alu_control   (alu_control_dec),
        .funct_illegal (funct_illegal)
    );
`else
    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control_dec)
    );
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_R:         state_nx = S_EXECR;
                    OP_I:         state_nx = S_EXECI;
                    OP_BEQ:       state_nx = S_BEQ;
                    OP_JAL:       state_nx = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_nx = S_ILLEGAL;
`else
                    default:      state_nx = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_nx = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_nx = S_MEMWB;
            S_MEMWB:    state_nx = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_nx = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_EXECR, S_EXECI: state_nx = funct_illegal ? S_ILLEGAL : S_ALUWB;
            S_ILLEGAL:  state_nx = S_ILLEGAL;
`else
            S_EXECR, S_EXECI: state_nx = S_ALUWB;
`endif
            S_ALUWB:    state_nx = S_FETCH;
            S_BEQ:      state_nx = S_FETCH;
            S_JAL:      state_nx = S_ALUWB;
            default:    state_nx = S_FETCH;
        endcase
    end

    assign waiting = !mem_ready &&
                     (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_FETCH;
            stall_cycles <= '0;
        end else begin
            state <= state_nx;
            if (waiting && stall_cycles != {STALL_CNT_W{1'b0}} - STALL_CNT_W'(1))
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

    // Decoded from the state register; gated by rst so nothing is asserted during reset,
    // and strobes that follow mem_ready/zero do so within the same cycle.
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        RegWrite  = 1'b0;
        alu_op    = ALUOP_ADD;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RD1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = RES_READDATA;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_RD1;
                    alu_op  = ALUOP_FUNC;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_RD1;
                    ALUSrcB = SRCB_IMM;
                    alu_op  = ALUOP_FUNC;
                end
                S_ALUWB:    RegWrite = 1'b1;
                S_BEQ: begin
                    ALUSrcA = SRCA_RD1;
                    alu_op  = ALUOP_SUB;
                    PCWrite = zero;
                end
                S_JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ALUControl = rst ? alu_control_dec : ALU_ADD;
    assign ImmSrc     = rst ? imm_src_of(op) : IMM_I;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = (state == S_ILLEGAL);
`endif

endmodule
